// File: rtl/bin_updown_counter_pkg.sv
// Shared types and constants for the button-driven up/down counter.
// Debounce FSM encoding plus the default counter width for the nominal debounce time.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } db_state_t;

    localparam int DB_CYCLES_DEFAULT = 50000;
    localparam int DB_CNT_W          = $clog2(DB_CYCLES_DEFAULT);

endpackage

// File: rtl/bin_updown_counter_debounce.sv
// One board button: 2-FF synchroniser, debounce FSM and stability counter.
// Emits a single-cycle press strobe once a press has been stable for DB_CYCLES samples.
module btn_debounce
    import counter_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int             CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          pressed;
    db_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    assign pressed = ~sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '1;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn_n};
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press   = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_n = PRESS_CHK;
                    cnt_n   = '0;
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    press   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_n = RELEASE_CHK;
                    cnt_n   = '0;
                end
            end
            RELEASE_CHK: begin
                if (pressed) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/bin_updown_counter.sv
// Wrapping up/down counter stepped by two debounced active-low push-buttons.
// Feeds the binary-to-BCD/7-segment decoder's BIN input.
module bin_updown_counter
    import counter_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int MAX_VAL   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    input  logic             en,
    output logic [CNT_W-1:0] bin_out,
    output logic             up_pulse,
    output logic             dn_pulse,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_VAL);

    logic up_s, dn_s;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_up_n),
        .press (up_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_dn_n),
        .press (dn_s)
    );

    // Simultaneous up and down presses cancel; strobes are still reported.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_out  <= '0;
            up_pulse <= 1'b0;
            dn_pulse <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            up_pulse <= up_s;
            dn_pulse <= dn_s;
            wrap     <= 1'b0;
            if (en && (up_s ^ dn_s)) begin
                if (up_s) begin
                    if (bin_out == MAX) begin
                        bin_out <= '0;
                        wrap    <= 1'b1;
                    end else begin
                        bin_out <= bin_out + CNT_W'(1);
                    end
                end else begin
                    if (bin_out == '0) begin
                        bin_out <= MAX;
                        wrap    <= 1'b1;
                    end else begin
                        bin_out <= bin_out - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_updown_counter.sv
// Scoreboard bench for bin_updown_counter with a short debounce time.
// Expected strobe events are queued at stimulus time and matched as the DUT emits them.
module tb_bin_updown_counter;

    localparam int CNT_W = 4;
    localparam int DB    = 4;
    localparam int MAXV  = 15;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             btn_up_n = 1'b0;
    logic             btn_dn_n = 1'b0;
    logic             en       = 1'b1;
    logic [CNT_W-1:0] bin_out;
    logic             up_pulse, dn_pulse, wrap;
    logic [6:0]       seg;

    bin_updown_counter #(
        .CNT_W     (CNT_W),
        .DB_CYCLES (DB),
        .MAX_VAL   (MAXV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up_n (btn_up_n),
        .btn_dn_n (btn_dn_n),
        .en       (en),
        .bin_out  (bin_out),
        .up_pulse (up_pulse),
        .dn_pulse (dn_pulse),
        .wrap     (wrap)
    );

    // Downstream 7-segment decoder (gfedcba, active-high)
    always_comb begin
        case (bin_out)
            4'h0: seg = 7'h3F; 4'h1: seg = 7'h06; 4'h2: seg = 7'h5B; 4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66; 4'h5: seg = 7'h6D; 4'h6: seg = 7'h7D; 4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F; 4'h9: seg = 7'h6F; 4'hA: seg = 7'h77; 4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39; 4'hD: seg = 7'h5E; 4'hE: seg = 7'h79; default: seg = 7'h71;
        endcase
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic       up;
        logic       dn;
        logic       wrap;
        logic [3:0] bin;
        int         at;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (up_pulse || dn_pulse || wrap)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {29'd0, up_pulse, dn_pulse, wrap}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("up_pulse", up_pulse, mon_e.up);
                check("dn_pulse", dn_pulse, mon_e.dn);
                check("wrap",     wrap,     mon_e.wrap);
                check("bin_out",  bin_out,  mon_e.bin);
                if (mon_e.at >= 0) check("latency", cyc, mon_e.at);
            end
        end
    end

    task automatic push_exp(input bit u, input bit d, input int at);
        exp_t e;
        e.up   = u;
        e.dn   = d;
        e.wrap = 1'b0;
        if (en && (u ^ d)) begin
            if (u) begin
                if (exp_cnt == 4'(MAXV)) begin exp_cnt = '0; e.wrap = 1'b1; end
                else exp_cnt = exp_cnt + 4'd1;
            end else begin
                if (exp_cnt == 4'd0) begin exp_cnt = 4'(MAXV); e.wrap = 1'b1; end
                else exp_cnt = exp_cnt - 4'd1;
            end
        end
        e.bin = exp_cnt;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic settle(input string tag);
        repeat (DB + 6) @(posedge clk);
        #1;
        check(tag, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic press(input bit u, input bit d, input int hold);
        @(posedge clk); #1;
        push_exp(u, d, cyc + 1 + DB + 2);
        if (u) btn_up_n = 1'b0;
        if (d) btn_dn_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        settle("sb_drained");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with both buttons held
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin", bin_out, 32'd0);
        check("rst_strobes", {up_pulse, dn_pulse, wrap}, 32'd0);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (DB + 8) @(posedge clk);
        #1;
        check("post_rst_bin", bin_out, 32'd0);
        check("post_rst_seg", seg, 32'h3F);
        check("post_rst_quiet", sb.size(), 32'd0);

        // 2: clean press held 10 cycles
        press(1'b1, 1'b0, 10);
        check("clean_bin", bin_out, 32'd1);

        // 3: bouncing press
        @(posedge clk); #1;
        push_exp(1'b1, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            btn_up_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        btn_up_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        btn_up_n = 1'b1;
        settle("bounce_drained");
        check("bounce_bin", bin_out, 32'd2);

        // 4: wrap both directions
        for (int i = 0; i < 13; i++) press(1'b1, 1'b0, 10);
        check("at_max_bin", bin_out, 32'd15);
        check("at_max_seg", seg, 32'h71);
        press(1'b1, 1'b0, 10);
        check("wrap_up_bin", bin_out, 32'd0);
        press(1'b0, 1'b1, 10);
        check("wrap_dn_bin", bin_out, 32'd15);
        press(1'b0, 1'b1, 10);
        check("dec_bin", bin_out, 32'd14);

        // 5: simultaneous presses and disabled count
        press(1'b1, 1'b1, 10);
        check("both_bin", bin_out, 32'd14);
        en = 1'b0;
        press(1'b1, 1'b0, 10);
        press(1'b0, 1'b1, 10);
        check("en0_bin", bin_out, 32'd14);
        en = 1'b1;

        // 6: reset in PRESS_CHK with counter at 2
        @(posedge clk); #1;
        btn_up_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        btn_up_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
        repeat (DB + 8) @(posedge clk);
        #1;
        check("midrst_bin", bin_out, 32'd0);
        check("midrst_quiet", sb.size(), 32'd0);
        press(1'b1, 1'b0, 10);
        check("after_rst_bin", bin_out, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
